// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// The op codes are the same values the ALU decoder drives on alucontrol.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
// acc is the upper half (partial product / remainder), q the lower half (multiplier / quotient).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  // NOTE: every output is given a default before any branch so no path can infer a latch.
  always_comb begin
    acc_nxt = acc;
    q_nxt   = q;
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shl     = {acc, q[WIDTH-1]};
    // Only the low WIDTH bits are needed: the kept difference is always below the divisor.
    diff    = shl[WIDTH-1:0] - m;
    if (is_div) begin
      if (shl >= {1'b0, m}) begin
        acc_nxt = diff;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shl[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer: one bit per clock, busy during RUN, done pulse with hi/lo.
// Optional MULDIV_EARLY_OUT_EN: a MUL leaves RUN once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, q, m;
  logic [WIDTH-1:0] acc_nxt, q_nxt;
  logic             op_div;
  logic             is_op, accept, div_zero, last_iter;
  logic [2*WIDTH-1:0] result;

  assign is_op    = (alucontrol == ALU_MUL) || (alucontrol == ALU_DIV);
  assign accept   = start && is_op && (state != RUN);
  assign div_zero = (alucontrol == ALU_DIV) && (b == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_div),
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] mb;
  logic [CW:0]      iters;
  logic [CW:0]      align;

  assign iters     = {1'b0, count} + 1'b1;
  assign align     = WIDTH[CW:0] - iters;
  assign last_iter = (count == LAST) || (!op_div && ((mb >> iters) == '0));
  // The skipped iterations would only shift right, so apply them in one step on exit.
  assign result    = {acc_nxt, q_nxt} >> align;

  always_ff @(posedge clk) begin
    if (reset) begin
      mb <= '0;
    end else if (accept) begin
      mb <= b;
    end
  end
`else
  assign last_iter = (count == LAST);
  assign result    = {acc_nxt, q_nxt};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = accept ? (div_zero ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      op_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      div0   <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      q   <= q_nxt;
      if (count != LAST) count <= count + 1'b1;
      if (last_iter) begin
        hi   <= op_div ? acc_nxt : result[2*WIDTH-1:WIDTH];
        lo   <= op_div ? q_nxt   : result[WIDTH-1:0];
        div0 <= 1'b0;
      end
    end else if (accept) begin
      count  <= '0;
      acc    <= '0;
      q      <= a;
      m      <= b;
      op_div <= (alucontrol == ALU_DIV);
      if (div_zero) begin
        hi   <= a;
        lo   <= '1;
        div0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of expected hi/lo/div0/latency/busy per operation.
// Honours MULDIV_EARLY_OUT_EN when computing expected MUL latency.
module tb_muldiv_seq;

  localparam int W = 32;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_BAD = 4'b0010;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   alucontrol;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div0       (div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
    int           nbusy;
    int           issue_cyc;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  function automatic int run_len(input logic [W-1:0] bv);
    int n;
`ifdef MULDIV_EARLY_OUT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // Called at a negedge; drives one start cycle and returns at the following negedge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [2*W-1:0] p;
    e.issue_cyc = cyc;
    e.div0      = 1'b0;
    if (op == OP_MUL) begin
      p       = 64'(av) * 64'(bv);
      e.hi    = p[2*W-1:W];
      e.lo    = p[W-1:0];
      e.nbusy = run_len(bv);
    end else if (bv == '0) begin
      e.hi    = av;
      e.lo    = '1;
      e.div0  = 1'b1;
      e.nbusy = 0;
    end else begin
      e.hi    = av % bv;
      e.lo    = av / bv;
      e.nbusy = W;
    end
    e.lat = e.nbusy + 1;
    sb.push_back(e);
    start = 1'b1; alucontrol = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; alucontrol = 4'b0000; a = $urandom; b = $urandom;
  endtask

  // Waits (bounded) for done, then compares against the oldest scoreboard entry.
  task automatic collect(input string name, input bit chk_busy);
    exp_t e;
    int   nb  = 0;
    bit   got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy === 1'b1) nb++;
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: done not seen within 200 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: done with no outstanding operation", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, e.hi); end
    checks++;
    if (lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, e.lo); end
    checks++;
    if (div0 !== e.div0) begin errors++; $display("FAIL %s div0: got %b expected %b", name, div0, e.div0); end
    checks++;
    if (cyc - e.issue_cyc != e.lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc - e.issue_cyc, e.lat);
    end
    if (chk_busy) begin
      checks++;
      if (nb != e.nbusy) begin errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, nb, e.nbusy); end
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; alucontrol = 4'b0000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset lo: got %h expected 0", lo); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset div0: got %b expected 0", div0); end
  endtask

  task automatic test_mul();
    issue(OP_MUL, 32'd7, 32'd6);
    collect("mul_7x6", 1'b1);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_pulse done: got %b expected 0", done); end
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect("mul_max", 1'b1);
    @(negedge clk);
    issue(OP_MUL, 32'd123456, 32'd0);
    collect("mul_by_zero", 1'b1);
    @(negedge clk);
    issue(OP_MUL, 32'h8000_0000, 32'h0000_0002);
    collect("mul_carry", 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(OP_MUL, $urandom, $urandom);
      collect("mul_rand", 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic test_div();
    issue(OP_DIV, 32'd100, 32'd7);
    collect("div_100_7", 1'b1);
    @(negedge clk);
    issue(OP_DIV, 32'd5, 32'd0);
    collect("div_by_zero", 1'b1);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL div0_pulse done: got %b expected 0", done); end
    issue(OP_DIV, 32'd3, 32'd10);
    collect("div_small", 1'b1);
    @(negedge clk);
    issue(OP_DIV, 32'hFFFF_FFFF, 32'd1);
    collect("div_by_one", 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      issue(OP_DIV, $urandom, $urandom_range(1, 65535));
      collect("div_rand", 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_op();
    bit activity = 1'b0;
    start = 1'b1; alucontrol = OP_BAD; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0; alucontrol = 4'b0000;
    repeat (5) begin
      if (busy !== 1'b0 || done !== 1'b0) activity = 1'b1;
      @(negedge clk);
    end
    checks++; if (activity) begin errors++; $display("FAIL illegal_op: busy/done seen, expected none"); end
    checks++; if (hi !== last_hi) begin errors++; $display("FAIL illegal_op hi: got %h expected %h", hi, last_hi); end
    checks++; if (lo !== last_lo) begin errors++; $display("FAIL illegal_op lo: got %h expected %h", lo, last_lo); end
  endtask

  task automatic test_start_in_run();
    bit seen = 1'b0;
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    start = 1'b1; alucontrol = OP_MUL; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; alucontrol = 4'b0000;
    collect("start_in_run", 1'b0);
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL start_in_run: extra done pulse from ignored start"); end
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    issue(OP_DIV, 32'hDEAD_BEEF, 32'd77);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    last_hi = '0;
    last_lo = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset done: got %b expected 0", done); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL mid_reset hi: got %h expected 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL mid_reset lo: got %h expected 0", lo); end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_reset: activity after reset, expected idle"); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] first_hi, first_lo;
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    collect("b2b_first", 1'b1);
    first_hi = last_hi;
    first_lo = last_lo;
    issue(OP_DIV, 32'd1000000, 32'd999);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b done after DONE: got %b expected 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b busy after DONE: got %b expected 1", busy); end
    checks++; if (hi !== first_hi) begin errors++; $display("FAIL b2b hi held: got %h expected %h", hi, first_hi); end
    collect("b2b_second", 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_illegal_op();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
